// File: rtl/sd_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sd_req_arbiter_pkg
// Shared SD definitions: block/address/wait-counter widths, the arbiter FSM
// state encoding and a small one-hot helper used by the arbiter and its
// round-robin sub-block.
// -----------------------------------------------------------------------------
package sd_req_arbiter_pkg;

    // SD controller data path geometry
    localparam int SD_BLOCK_W = 512;   // one SD block, in bits
    localparam int SD_ADDR_W  = 32;    // block address width
    localparam int SD_WAIT_W  = 24;    // wait/timeout counter width

    typedef logic [SD_BLOCK_W-1:0] sd_block_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_WAIT_WR = 3'd3,
        ST_FINISH  = 3'd4
    } sd_arb_state_e;

    // Requester index (0/1) to a one-hot 2-bit vector
    function automatic logic [1:0] sd_onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sd_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// sd_req_arbiter_if
// Requester-side bus of the SD request arbiter.
//   req/req_we            : per-requester level request and op (1 = write)
//   req_addr0/1           : block address per requester
//   req_wdata0/1          : write block per requester
//   gnt                   : one-hot current owner
//   done/err              : one-cycle completion / error pulse to the owner
//   rdata                 : last block read
// master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface sd_req_arbiter_if;
    import sd_req_arbiter_pkg::*;

    logic [1:0]           req;
    logic [1:0]           req_we;
    logic [SD_ADDR_W-1:0] req_addr0;
    logic [SD_ADDR_W-1:0] req_addr1;
    sd_block_t            req_wdata0;
    sd_block_t            req_wdata1;
    logic [1:0]           gnt;
    logic [1:0]           done;
    logic [1:0]           err;
    sd_block_t            rdata;

    modport master (
        output req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  gnt, done, err, rdata
    );

    modport slave (
        input  req, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output gnt, done, err, rdata
    );

endinterface

// File: rtl/sd_req_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// sd_rr_arb2
// Two-way round-robin grant selection. The pointer names the requester that
// wins a tie; after reset requester 0 wins. On i_update the pointer moves to
// the requester that was not just served.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : request vector
//   i_update       : end of a transaction (done or abort)
//   i_served       : index of the requester that owned that transaction
//   o_valid        : at least one request present
//   o_idx          : selected requester index (meaningful when o_valid)
// -----------------------------------------------------------------------------
module sd_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_served,
    output logic       o_valid,
    output logic       o_idx
);

    logic r_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_update) begin
            r_ptr <= ~i_served;
        end
    end

    // Single requester wins outright; a tie is broken by the pointer.
    always_comb begin
        o_valid = |i_req;
        o_idx   = (i_req == 2'b11) ? r_ptr : i_req[1];
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// -----------------------------------------------------------------------------
// sd_req_arbiter
// Shares one SD block controller between two requesters. A request is granted
// when the controller is initialised and idle, its operands are latched, a
// read-start pulse or a write-enable level is issued, and the owner gets a
// done pulse on completion or an err pulse on controller error / timeout.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   req_bus (slave)       : requester bus (req/we/addr/wdata in, gnt/done/err/rdata out)
//   i_sd_init_complete    : controller initialised
//   i_sd_busy             : controller busy, blocks new grants
//   i_sd_data_valid       : read block available on i_sd_rdata
//   i_sd_write_complete   : write finished
//   i_sd_error            : controller error
//   i_sd_rdata            : controller read data
//   o_sd_read_next_block  : one-cycle read start
//   o_sd_write_enable     : write request level, held while waiting
//   o_sd_block_addr       : latched block address
//   o_sd_write_data       : latched write block
// TIMEOUT_CYC must be at least 1.
// -----------------------------------------------------------------------------
module sd_req_arbiter
    import sd_req_arbiter_pkg::*;
#(
    parameter logic [SD_WAIT_W-1:0] TIMEOUT_CYC = 24'd5_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sd_req_arbiter_if.slave      req_bus,
    input  logic                 i_sd_init_complete,
    input  logic                 i_sd_busy,
    input  logic                 i_sd_data_valid,
    input  logic                 i_sd_write_complete,
    input  logic                 i_sd_error,
    input  sd_block_t            i_sd_rdata,
    output logic                 o_sd_read_next_block,
    output logic                 o_sd_write_enable,
    output logic [SD_ADDR_W-1:0] o_sd_block_addr,
    output sd_block_t            o_sd_write_data
);

    // Abort fires on the wait cycle in which the counter shows TIMEOUT_CYC-1,
    // i.e. on the TIMEOUT_CYC-th wait cycle.
    localparam logic [SD_WAIT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYC - SD_WAIT_W'(1);

    sd_arb_state_e        r_state;
    sd_arb_state_e        w_state_next;

    logic                 r_owner;
    logic                 r_we;
    logic [1:0]           r_gnt;
    logic [1:0]           r_err;
    logic [SD_ADDR_W-1:0] r_addr;
    sd_block_t            r_wdata;
    sd_block_t            r_rdata;
    logic [SD_WAIT_W-1:0] r_wait_cnt;

    logic                 w_arb_valid;
    logic                 w_arb_idx;
    logic                 w_arb_update;
    logic                 w_grant;
    logic                 w_abort;
    logic                 w_capture;
    logic                 w_timeout;
    logic                 w_rd_pulse;
    logic                 w_wr_en;
    logic [1:0]           w_done;

    sd_rr_arb2 u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (req_bus.req),
        .i_update (w_arb_update),
        .i_served (r_owner),
        .o_valid  (w_arb_valid),
        .o_idx    (w_arb_idx)
    );

    assign w_grant      = (r_state == ST_IDLE) && i_sd_init_complete &&
                          !i_sd_busy && w_arb_valid;
    assign w_timeout    = (r_wait_cnt >= TIMEOUT_LAST);
    assign w_arb_update = w_abort || (r_state == ST_FINISH);

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    // sd_error is tested before data_valid / write_complete so an error in
    // the same cycle always wins.
    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_grant) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (i_sd_error) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = r_we ? ST_WAIT_WR : ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (i_sd_error || w_timeout) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (i_sd_data_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_FINISH;
                end
            end
            ST_WAIT_WR: begin
                if (i_sd_error || w_timeout) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (i_sd_write_complete) begin
                    w_state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        w_rd_pulse = 1'b0;
        w_wr_en    = 1'b0;
        w_done     = 2'b00;
        unique case (r_state)
            ST_ISSUE:   w_rd_pulse = !r_we;
            ST_WAIT_WR: w_wr_en    = 1'b1;
            ST_FINISH:  w_done     = r_gnt;
            default:    ;
        endcase
    end

    // ---------------- datapath: grant, operands, counter, results ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_gnt      <= 2'b00;
            r_err      <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_err <= 2'b00;

            if (w_grant) begin
                r_owner <= w_arb_idx;
                r_gnt   <= sd_onehot2(w_arb_idx);
                r_we    <= req_bus.req_we[w_arb_idx];
                r_addr  <= w_arb_idx ? req_bus.req_addr1  : req_bus.req_addr0;
                r_wdata <= w_arb_idx ? req_bus.req_wdata1 : req_bus.req_wdata0;
            end

            // Counter restarts every time a wait state is entered from ISSUE.
            if (r_state == ST_ISSUE) begin
                r_wait_cnt <= '0;
            end else if ((r_state == ST_WAIT_RD) || (r_state == ST_WAIT_WR)) begin
                r_wait_cnt <= r_wait_cnt + SD_WAIT_W'(1);
            end

            if (w_capture) begin
                r_rdata <= i_sd_rdata;
            end

            // err is registered, so it lands in the first IDLE cycle while
            // gnt drops at the same edge.
            if (w_abort) begin
                r_err <= r_gnt;
                r_gnt <= 2'b00;
            end else if (r_state == ST_FINISH) begin
                r_gnt <= 2'b00;
            end
        end
    end

    assign req_bus.gnt   = r_gnt;
    assign req_bus.done  = w_done;
    assign req_bus.err   = r_err;
    assign req_bus.rdata = r_rdata;

    assign o_sd_read_next_block = w_rd_pulse;
    assign o_sd_write_enable    = w_wr_en;
    assign o_sd_block_addr      = r_addr;
    assign o_sd_write_data      = r_wdata;

endmodule
